// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter
//
// Shares one multi-cycle resource between two pipelines. At most one
// transaction is in flight. Ties go to the pipeline that was not granted
// most recently. An owner that flushes its in-flight request still lets the
// resource finish, but it does not receive a response.
//
// Ports
//   clk, reset                : clock; asynchronous active-high reset
//   req_valid_x, req_data_x   : request and operand from pipeline x (1/2)
//   flush_x                   : pipeline x discards its pending/in-flight request
//   stall_x                   : request from pipeline x not accepted this cycle
//   res_start, res_data       : one-cycle start pulse and operand to the resource
//   res_done, res_result      : one-cycle completion pulse and result from the resource
//   resp_valid_x, resp_data_x : one-cycle response to pipeline x; data holds otherwise

module shared_resource_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_1,
    input  logic              req_valid_2,
    input  logic [DATA_W-1:0] req_data_1,
    input  logic [DATA_W-1:0] req_data_2,
    input  logic              flush_1,
    input  logic              flush_2,
    output logic              stall_1,
    output logic              stall_2,
    output logic              res_start,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_done,
    input  logic [DATA_W-1:0] res_result,
    output logic              resp_valid_1,
    output logic              resp_valid_2,
    output logic [DATA_W-1:0] resp_data_1,
    output logic [DATA_W-1:0] resp_data_2
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic              owner_2;       // 1: pipeline 2 owns the transaction
    logic              last_grant_2;  // 1: pipeline 2 was granted most recently
    logic              drop;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] hold_1;
    logic [DATA_W-1:0] hold_2;

    logic accept_1;
    logic accept_2;
    logic grant_1;
    logic grant_2;
    logic flush_owner;
    logic discard;

    // A flushed request is not a contender. On a tie, the pipeline that
    // lost last time wins.
    always_comb begin
        accept_1    = req_valid_1 & ~flush_1;
        accept_2    = req_valid_2 & ~flush_2;
        grant_1     = (state == IDLE) & accept_1 & (~accept_2 | last_grant_2);
        grant_2     = (state == IDLE) & accept_2 & (~accept_1 | ~last_grant_2);
        stall_1     = accept_1 & ~grant_1;
        stall_2     = accept_2 & ~grant_2;
        flush_owner = owner_2 ? flush_2 : flush_1;
        // A flush that arrives in the RESP cycle suppresses that cycle's
        // response immediately. The registered drop flag cannot take effect
        // until the next cycle.
        discard      = drop | flush_owner;
        res_start    = (state == ISSUE);
        res_data     = operand_q;
        resp_valid_1 = (state == RESP) & ~owner_2 & ~discard;
        resp_valid_2 = (state == RESP) & owner_2 & ~discard;
        resp_data_1  = resp_valid_1 ? result_q : hold_1;
        resp_data_2  = resp_valid_2 ? result_q : hold_2;
    end

    // Transaction FSM. A res_done that arrives in ISSUE is taken directly.
    // A res_done that arrives in IDLE or RESP belongs to no live
    // transaction, so it is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner_2      <= 1'b0;
            last_grant_2 <= 1'b1;
            drop         <= 1'b0;
            operand_q    <= '0;
            result_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_1 | grant_2) begin
                        owner_2      <= grant_2;
                        last_grant_2 <= grant_2;
                        operand_q    <= grant_2 ? req_data_2 : req_data_1;
                        drop         <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush_owner) begin
                        drop <= 1'b1;
                    end
                    if (res_done) begin
                        result_q <= res_result;
                        state    <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_owner) begin
                        drop <= 1'b1;
                    end
                    if (res_done) begin
                        result_q <= res_result;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (flush_owner) begin
                        drop <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Each pipeline's response data stays at its last delivered value while
    // its response valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_1 <= '0;
            hold_2 <= '0;
        end else begin
            if (resp_valid_1) begin
                hold_1 <= result_q;
            end
            if (resp_valid_2) begin
                hold_2 <= result_q;
            end
        end
    end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// tb_shared_resource_arbiter
//
// Directed bench for shared_resource_arbiter. Expected values are worked
// out by hand for each step. Inputs are driven 1 ns after the rising edge,
// and outputs are checked 2 ns after the rising edge.

module tb_shared_resource_arbiter;

    logic        clk;
    logic        reset;
    logic        req_valid_1;
    logic        req_valid_2;
    logic [31:0] req_data_1;
    logic [31:0] req_data_2;
    logic        flush_1;
    logic        flush_2;
    logic        stall_1;
    logic        stall_2;
    logic        res_start;
    logic [31:0] res_data;
    logic        res_done;
    logic [31:0] res_result;
    logic        resp_valid_1;
    logic        resp_valid_2;
    logic [31:0] resp_data_1;
    logic [31:0] resp_data_2;

    int vectors;
    int miscompares;
    int w;
    logic [31:0] op;

    shared_resource_arbiter #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_1  (req_valid_1),
        .req_valid_2  (req_valid_2),
        .req_data_1   (req_data_1),
        .req_data_2   (req_data_2),
        .flush_1      (flush_1),
        .flush_2      (flush_2),
        .stall_1      (stall_1),
        .stall_2      (stall_2),
        .res_start    (res_start),
        .res_data     (res_data),
        .res_done     (res_done),
        .res_result   (res_result),
        .resp_valid_1 (resp_valid_1),
        .resp_valid_2 (resp_valid_2),
        .resp_data_1  (resp_data_1),
        .resp_data_2  (resp_data_2)
    );

    // Free-running clock with rising edges at 5, 15, 25, ... ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv1, input logic [31:0] d1, input logic f1,
                                 input logic rv2, input logic [31:0] d2, input logic f2,
                                 input logic done, input logic [31:0] result);
        req_valid_1 = rv1;
        req_data_1  = d1;
        flush_1     = f1;
        req_valid_2 = rv2;
        req_data_2  = d2;
        flush_2     = f2;
        res_done    = done;
        res_result  = result;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence:
    // reset -> tie fairness -> single request -> flush at request ->
    // flush in flight -> back-to-back done -> reset mid-operation.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        tick();
        #1;
        checkOutput("rst_res_start", res_start, 1'b0);
        checkOutput("rst_res_data", res_data, 32'h0);
        checkOutput("rst_resp_valid_1", resp_valid_1, 1'b0);
        checkOutput("rst_resp_valid_2", resp_valid_2, 1'b0);
        checkOutput("rst_resp_data_1", resp_data_1, 32'h0);
        checkOutput("rst_resp_data_2", resp_data_2, 32'h0);
        checkOutput("rst_stall_1", stall_1, 1'b0);
        checkOutput("rst_stall_2", stall_2, 1'b1);
        reset = 1'b0;

        // Both pipelines hold requests continuously. Grants alternate 1,2,1,2,
        // and the resource returns operand+1.
        for (int g = 0; g < 4; g++) begin
            w  = (g % 2 == 0) ? 1 : 2;
            op = (w == 1) ? 32'h10 : 32'h20;
            #1;
            checkOutput("tie_stall_1", stall_1, w == 2);
            checkOutput("tie_stall_2", stall_2, w == 1);
            tick();
            #1;
            checkOutput("tie_res_start", res_start, 1'b1);
            checkOutput("tie_res_data", res_data, op);
            tick();
            applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, op + 32'h1);
            #1;
            checkOutput("tie_loser_stall", (w == 1) ? stall_2 : stall_1, 1'b1);
            tick();
            applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
            #1;
            checkOutput("tie_winner_valid", (w == 1) ? resp_valid_1 : resp_valid_2, 1'b1);
            checkOutput("tie_winner_data", (w == 1) ? resp_data_1 : resp_data_2, op + 32'h1);
            checkOutput("tie_loser_valid", (w == 1) ? resp_valid_2 : resp_valid_1, 1'b0);
            tick();
        end

        // Single request from pipeline 1. res_done arrives 3 cycles after res_start.
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("single_stall_1", stall_1, 1'b0);
        checkOutput("single_no_start_yet", res_start, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("single_res_start", res_start, 1'b1);
        checkOutput("single_res_data", res_data, 32'h11);
        tick();
        #1;
        checkOutput("single_start_one_cycle", res_start, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22);
        #1;
        checkOutput("single_no_early_resp", resp_valid_1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("single_resp_valid_1", resp_valid_1, 1'b1);
        checkOutput("single_resp_data_1", resp_data_1, 32'h22);
        checkOutput("single_resp_valid_2", resp_valid_2, 1'b0);
        tick();
        #1;
        checkOutput("single_valid_drops", resp_valid_1, 1'b0);
        checkOutput("single_data_holds", resp_data_1, 32'h22);

        // Flush at request: pipeline 1 flushes, so pipeline 2 wins alone.
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("flushreq_stall_1", stall_1, 1'b0);
        checkOutput("flushreq_stall_2", stall_2, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("flushreq_res_data", res_data, 32'h33);

        // Flush in flight: pipeline 2 flushes during WAIT. The resource still
        // completes, but no response is delivered.
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("flush_wait_valid_2", resp_valid_2, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h44);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("flush_no_resp_2", resp_valid_2, 1'b0);
        checkOutput("flush_no_resp_1", resp_valid_1, 1'b0);
        checkOutput("flush_data_holds_2", resp_data_2, 32'h21);
        tick();

        // The next request is accepted normally. Its res_done arrives in the
        // ISSUE cycle (back-to-back).
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("after_flush_stall_2", stall_2, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h56);
        #1;
        checkOutput("b2b_res_start", res_start, 1'b1);
        checkOutput("b2b_res_data", res_data, 32'h55);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("b2b_resp_valid_2", resp_valid_2, 1'b1);
        checkOutput("b2b_resp_data_2", resp_data_2, 32'h56);
        checkOutput("b2b_no_restart", res_start, 1'b0);
        tick();
        #1;
        checkOutput("b2b_valid_drops", resp_valid_2, 1'b0);

        // Reset mid-operation: assert reset in WAIT. A res_done after release
        // is ignored, and the first tie goes to pipeline 1.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h66, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("midrst_res_start", res_start, 1'b0);
        checkOutput("midrst_resp_valid_2", resp_valid_2, 1'b0);
        checkOutput("midrst_resp_data_2", resp_data_2, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77);
        #1;
        checkOutput("stale_done_valid_1", resp_valid_1, 1'b0);
        checkOutput("stale_done_valid_2", resp_valid_2, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h88, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("stale_done_no_start", res_start, 1'b0);
        checkOutput("stale_done_no_resp", resp_valid_2, 1'b0);
        checkOutput("post_rst_tie_stall_1", stall_1, 1'b0);
        checkOutput("post_rst_tie_stall_2", stall_2, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("post_rst_res_data", res_data, 32'h88);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shared_resource_arbiter.md
SHARED_RESOURCE_ARBITER -- requirements
Module: shared_resource_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of request, resource and response data.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid_1 / req_valid_2, input, 1: pipeline 1/2 requests the shared resource.
REQ-005 SHALL have ports req_data_1 / req_data_2, input, DATA_W: operand for pipeline 1/2.
REQ-006 SHALL have ports flush_1 / flush_2, input, 1: pipeline 1/2 discards its pending or in-flight request.
REQ-007 SHALL have ports stall_1 / stall_2, output, 1: request not accepted this cycle; requester holds it stable.
REQ-008 SHALL have port res_start, output, 1: one-cycle start pulse to the shared resource.
REQ-009 SHALL have port res_data, output, DATA_W: operand to the resource, valid while res_start=1.
REQ-010 SHALL have port res_done, input, 1: resource result valid, one-cycle pulse.
REQ-011 SHALL have port res_result, input, DATA_W: resource result, valid while res_done=1.
REQ-012 SHALL have ports resp_valid_1 / resp_valid_2, output, 1: one-cycle response pulse to pipeline 1/2.
REQ-013 SHALL have ports resp_data_1 / resp_data_2, output, DATA_W: response data, valid with resp_valid_x.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one request in flight at most.
REQ-015 IDLE: accept_x = req_valid_x & ~flush_x; if any accepted, SHALL latch winner as owner, latch its req_data, go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: single contender wins; on tie the pipeline not granted last wins; last_grant updates on each acceptance.
REQ-017 stall_x SHALL be combinational: req_valid_x & ~flush_x & ~(state==IDLE & x is winner).
REQ-018 ISSUE: SHALL assert res_start=1 and res_data=latched operand for exactly one cycle, then go to WAIT.
REQ-019 WAIT: SHALL hold until res_done=1, latch res_result, go to RESP; res_done in ISSUE SHALL also be taken (go directly to RESP).
REQ-020 RESP: SHALL pulse resp_valid_owner=1 with resp_data_owner=latched result unless the drop flag is set, then go to IDLE.
REQ-021 Latency: request accepted in cycle t -> res_start at t+1 -> response one cycle after res_done; next acceptance no earlier than the cycle after RESP.
REQ-022 flush_owner in ISSUE, WAIT or RESP SHALL set drop flag; the resource transaction still completes; no resp_valid is produced.
REQ-023 flush of the non-owner SHALL not affect the in-flight transaction.
REQ-024 flush_x and req_valid_x together in IDLE SHALL not accept, stall_x=0; the other pipeline may still win.
REQ-025 res_done in IDLE or RESP SHALL be ignored.
REQ-026 resp_data_x SHALL hold its last value when resp_valid_x=0; only the owner's resp_valid ever asserts.

Reset
REQ-027 On reset, SHALL go to IDLE asynchronously: res_start=0, resp_valid_1/2=0, stall_1/2 combinational from inputs, drop=0, resp_data/res_data=0, last_grant=2 (pipeline 1 wins first tie).
REQ-028 Reset mid-transaction SHALL abandon it; a later res_done for it SHALL be ignored per REQ-025.

Verification
REQ-029 Single request: req_valid_1=1, data 0x11, res_done 3 cycles after res_start with result 0x22 -> stall_1=0 at t, res_start at t+1, resp_valid_1=1 with resp_data_1=0x22 one cycle after res_done, resp_valid_2 never asserts.
REQ-030 Tie fairness: both request continuously out of reset, resource returns operand+1 -> grants alternate 1,2,1,2; the loser's stall stays 1 until granted; each response carries its own operand+1.
REQ-031 Flush in flight: pipeline 2 owns, flush_2 pulsed during WAIT -> res_done arrives, no resp_valid_2; FSM reaches IDLE; next request accepted normally.
REQ-032 Flush at request: req_valid_1=flush_1=1, req_valid_2=1 in IDLE -> pipeline 2 accepted, stall_1=0, stall_2=0.
REQ-033 Reset mid-op: assert reset in WAIT, then res_done pulse after release -> no resp_valid, res_start=0, the first tie goes to pipeline 1.
REQ-034 Back-to-back: res_done in ISSUE cycle -> state goes directly to RESP, response still delivered.
